// File: rtl/avalon_burst_arbiter.sv
// Two-master Avalon-MM burst arbiter: round-robin ownership of one slave,
// held for a whole burst, with an optional stall timeout.
module avalon_burst_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic [29:0] i_M0_AV_Addr,
   input  logic [3:0]  i_M0_AV_ByteEn,
   input  logic        i_M0_AV_Read,
   input  logic        i_M0_AV_Write,
   input  logic [31:0] i_M0_AV_WriteData,
   input  logic [7:0]  i_M0_AV_BurstCount,
   output logic [31:0] o_M0_AV_ReadData,
   output logic        o_M0_AV_WaitRequest,
   input  logic [29:0] i_M1_AV_Addr,
   input  logic [3:0]  i_M1_AV_ByteEn,
   input  logic        i_M1_AV_Read,
   input  logic        i_M1_AV_Write,
   input  logic [31:0] i_M1_AV_WriteData,
   input  logic [7:0]  i_M1_AV_BurstCount,
   output logic [31:0] o_M1_AV_ReadData,
   output logic        o_M1_AV_WaitRequest,
   output logic [29:0] o_S_AV_Addr,
   output logic [3:0]  o_S_AV_ByteEn,
   output logic        o_S_AV_Read,
   output logic        o_S_AV_Write,
   output logic [31:0] o_S_AV_WriteData,
   output logic [7:0]  o_S_AV_BurstCount,
   input  logic [31:0] i_S_AV_ReadData,
   input  logic        i_S_AV_WaitRequest,
   output logic [1:0]  o_Grant,
   output logic        o_Timeout
);

   localparam int SW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [7:0]    beat_q, beat_d;
   logic [SW-1:0] stall_q, stall_d;
   logic          timeout_q, timeout_d;

   logic req0, req1;
   logic sel0, sel1;
   logic accept;

   assign req0 = i_M0_AV_Read | i_M0_AV_Write;
   assign req1 = i_M1_AV_Read | i_M1_AV_Write;

   // Reset low gates the slave side at once so an aborted burst emits no beat.
   assign sel0 = (state_q == GRANT0) & i_Rst_n;
   assign sel1 = (state_q == GRANT1) & i_Rst_n;

   assign o_Grant   = {sel1, sel0};
   assign o_Timeout = timeout_q;

   always_comb begin
      o_S_AV_Addr         = '0;
      o_S_AV_ByteEn       = '0;
      o_S_AV_Read         = 1'b0;
      o_S_AV_Write        = 1'b0;
      o_S_AV_WriteData    = '0;
      o_S_AV_BurstCount   = '0;
      o_M0_AV_ReadData    = '0;
      o_M0_AV_WaitRequest = 1'b1;
      o_M1_AV_ReadData    = '0;
      o_M1_AV_WaitRequest = 1'b1;
      if (sel0) begin
         o_S_AV_Addr         = i_M0_AV_Addr;
         o_S_AV_ByteEn       = i_M0_AV_ByteEn;
         o_S_AV_Read         = i_M0_AV_Read & ~i_M0_AV_Write;
         o_S_AV_Write        = i_M0_AV_Write;
         o_S_AV_WriteData    = i_M0_AV_WriteData;
         o_S_AV_BurstCount   = i_M0_AV_BurstCount;
         o_M0_AV_ReadData    = i_S_AV_ReadData;
         o_M0_AV_WaitRequest = i_S_AV_WaitRequest;
      end else if (sel1) begin
         o_S_AV_Addr         = i_M1_AV_Addr;
         o_S_AV_ByteEn       = i_M1_AV_ByteEn;
         o_S_AV_Read         = i_M1_AV_Read & ~i_M1_AV_Write;
         o_S_AV_Write        = i_M1_AV_Write;
         o_S_AV_WriteData    = i_M1_AV_WriteData;
         o_S_AV_BurstCount   = i_M1_AV_BurstCount;
         o_M1_AV_ReadData    = i_S_AV_ReadData;
         o_M1_AV_WaitRequest = i_S_AV_WaitRequest;
      end
   end

   assign accept = (o_S_AV_Read | o_S_AV_Write) & ~i_S_AV_WaitRequest;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      beat_d       = beat_q;
      stall_d      = stall_q;
      timeout_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // M0 wins a tie only when M1 owned the bus last.
            if (req0 && (!req1 || last_grant_q)) begin
               state_d      = GRANT0;
               last_grant_d = 1'b0;
               beat_d       = (i_M0_AV_BurstCount == 8'd0) ?
                              8'd1 : i_M0_AV_BurstCount;
               stall_d      = '0;
            end else if (req1) begin
               state_d      = GRANT1;
               last_grant_d = 1'b1;
               beat_d       = (i_M1_AV_BurstCount == 8'd0) ?
                              8'd1 : i_M1_AV_BurstCount;
               stall_d      = '0;
            end
         end
         GRANT0, GRANT1: begin
            if (accept) begin
               beat_d  = beat_q - 8'd1;
               stall_d = '0;
               if (beat_q == 8'd1) begin
                  state_d = IDLE;
               end
            end else begin
               stall_d = stall_q + SW'(1);
               if (TIMEOUT_CYCLES != 0 && stall_d == STALL_MAX) begin
                  state_d   = IDLE;
                  timeout_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         beat_q       <= '0;
         stall_q      <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         beat_q       <= beat_d;
         stall_q      <= stall_d;
         timeout_q    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Scoreboard bench for avalon_burst_arbiter: directed scenarios push the
// expected slave beats and grant runs; a negedge monitor pops and compares.
module tb_avalon_burst_arbiter;

   logic        clk;
   logic        rst_n;
   logic [29:0] m0_addr, m1_addr;
   logic [3:0]  m0_be, m1_be;
   logic        m0_rd, m0_wr, m1_rd, m1_wr;
   logic [31:0] m0_wd, m1_wd;
   logic [7:0]  m0_bc, m1_bc;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_wait, m1_wait;
   logic [29:0] s_addr;
   logic [3:0]  s_be;
   logic        s_rd, s_wr;
   logic [31:0] s_wd;
   logic [7:0]  s_bc;
   logic [31:0] s_rdata;
   logic        s_wait;
   logic [1:0]  grant;
   logic        tmo;

   avalon_burst_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .i_Clk(clk),
      .i_Rst_n(rst_n),
      .i_M0_AV_Addr(m0_addr),
      .i_M0_AV_ByteEn(m0_be),
      .i_M0_AV_Read(m0_rd),
      .i_M0_AV_Write(m0_wr),
      .i_M0_AV_WriteData(m0_wd),
      .i_M0_AV_BurstCount(m0_bc),
      .o_M0_AV_ReadData(m0_rdata),
      .o_M0_AV_WaitRequest(m0_wait),
      .i_M1_AV_Addr(m1_addr),
      .i_M1_AV_ByteEn(m1_be),
      .i_M1_AV_Read(m1_rd),
      .i_M1_AV_Write(m1_wr),
      .i_M1_AV_WriteData(m1_wd),
      .i_M1_AV_BurstCount(m1_bc),
      .o_M1_AV_ReadData(m1_rdata),
      .o_M1_AV_WaitRequest(m1_wait),
      .o_S_AV_Addr(s_addr),
      .o_S_AV_ByteEn(s_be),
      .o_S_AV_Read(s_rd),
      .o_S_AV_Write(s_wr),
      .o_S_AV_WriteData(s_wd),
      .o_S_AV_BurstCount(s_bc),
      .i_S_AV_ReadData(s_rdata),
      .i_S_AV_WaitRequest(s_wait),
      .o_Grant(grant),
      .o_Timeout(tmo)
   );

   typedef struct {
      logic [1:0]  g;
      logic        rd;
      logic        wr;
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [7:0]  bc;
   } beat_t;

   typedef struct {
      logic [1:0] g;
      int         len;
   } run_t;

   beat_t exp_beats[$];
   run_t  exp_runs[$];

   int total = 0;
   int bad   = 0;
   int mode  = 0;
   int scnt  = 0;
   int to_cnt = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] wd_of(input int m, input logic [29:0] a,
                                         input int i);
      return {4'hA, 4'(m), 16'(a), 8'(i)};
   endfunction

   task automatic push_beat(input logic [1:0] g, input logic rd,
                            input logic wr, input logic [29:0] a,
                            input logic [3:0] be, input logic [31:0] wd,
                            input logic [7:0] bc);
      beat_t b;
      b.g = g; b.rd = rd; b.wr = wr; b.addr = a;
      b.be = be; b.wd = wd; b.bc = bc;
      exp_beats.push_back(b);
   endtask

   task automatic push_run(input logic [1:0] g, input int len);
      run_t r;
      r.g = g; r.len = len;
      exp_runs.push_back(r);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int m, input logic rd, input logic wr,
                        input logic [29:0] a, input logic [7:0] bc,
                        input logic [31:0] wd);
      if (m == 0) begin
         m0_rd = rd; m0_wr = wr; m0_addr = a;
         m0_bc = bc; m0_wd = wd; m0_be = 4'hF;
      end else begin
         m1_rd = rd; m1_wr = wr; m1_addr = a;
         m1_bc = bc; m1_wd = wd; m1_be = 4'h3;
      end
   endtask

   function automatic logic wt(input int m);
      return (m == 0) ? m0_wait : m1_wait;
   endfunction

   task automatic drive_m(input int m, input logic rd, input logic wr,
                          input logic [29:0] a, input logic [7:0] bc,
                          input int beats, input int gap);
      int n;
      for (int i = 0; i < beats; i++) begin
         set_m(m, rd, wr, a, bc, wd_of(m, a, i));
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (wt(m) && n < 200);
         if (wt(m)) begin
            total++;
            bad++;
            $display("FAIL drv_hang m%0d: got wait=1 want 0", m);
         end
         tick();
         if (gap > 0 && i < beats - 1) begin
            set_m(m, 1'b0, 1'b0, a, bc, '0);
            repeat (gap) tick();
         end
      end
      set_m(m, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_grant", grant, 2'b00);
      chk("rst_tmo", tmo, 1'b0);
      chk("rst_w0", m0_wait, 1'b1);
      chk("rst_w1", m1_wait, 1'b1);
      chk("rst_srd", s_rd, 1'b0);
      chk("rst_swr", s_wr, 1'b0);
      chk("rst_saddr", s_addr, 30'h0);
      chk("rst_sbc", s_bc, 8'h0);
      tick();
      rst_n = 1'b1;
   endtask

   // Slave model: 0 = never stall, 1 = stall two cycles per beat, 2 = stuck.
   initial begin
      s_wait  = 1'b0;
      s_rdata = 32'hD000_0000;
      forever begin
         @(posedge clk);
         #2;
         s_rdata = s_rdata + 32'h11;
         case (mode)
            1: begin
               if (s_rd | s_wr) begin
                  if (scnt < 2) begin
                     s_wait = 1'b1;
                     scnt++;
                  end else begin
                     s_wait = 1'b0;
                     scnt = 0;
                  end
               end else begin
                  s_wait = 1'b0;
               end
            end
            2: s_wait = 1'b1;
            default: s_wait = 1'b0;
         endcase
      end
   end

   initial begin
      logic [1:0] prev_g;
      int         run;
      beat_t      e;
      run_t       r;
      prev_g = 2'b00;
      run    = 0;
      forever begin
         @(negedge clk);
         if ((s_rd | s_wr) && !s_wait) begin
            if (exp_beats.size() == 0) begin
               chk("beat_unexpected", {30'h0, grant}, 32'h0);
            end else begin
               e = exp_beats.pop_front();
               chk("beat_grant", grant, e.g);
               chk("beat_rd", s_rd, e.rd);
               chk("beat_wr", s_wr, e.wr);
               chk("beat_addr", s_addr, e.addr);
               chk("beat_be", s_be, e.be);
               chk("beat_bc", s_bc, e.bc);
               if (e.wr) chk("beat_wd", s_wd, e.wd);
               if (e.rd && e.g == 2'b01) chk("rdata_m0", m0_rdata, s_rdata);
               if (e.rd && e.g == 2'b10) chk("rdata_m1", m1_rdata, s_rdata);
            end
         end
         if (!grant[0]) begin
            chk("idle_w0", m0_wait, 1'b1);
            chk("idle_rd0", m0_rdata, 32'h0);
         end
         if (!grant[1]) begin
            chk("idle_w1", m1_wait, 1'b1);
            chk("idle_rd1", m1_rdata, 32'h0);
         end
         if (tmo) to_cnt++;
         if (prev_g != 2'b00 && grant != prev_g) begin
            chk("dead_cycle", grant, 2'b00);
            if (exp_runs.size() == 0) begin
               chk("run_unexpected", prev_g, 2'b00);
            end else begin
               r = exp_runs.pop_front();
               chk("run_grant", prev_g, r.g);
               chk("run_len", run, r.len);
            end
         end
         if (grant != 2'b00) run = (grant == prev_g) ? run + 1 : 1;
         prev_g = grant;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      set_m(0, 1'b0, 1'b0, '0, '0, '0);
      set_m(1, 1'b0, 1'b0, '0, '0, '0);
      do_reset();

      // Single 4-beat write burst from M0, no slave stall.
      for (int i = 0; i < 4; i++)
         push_beat(2'b01, 1'b0, 1'b1, 30'h100, 4'hF, wd_of(0, 30'h100, i), 8'd4);
      push_run(2'b01, 4);
      tick();
      drive_m(0, 1'b0, 1'b1, 30'h100, 8'd4, 4, 0);
      repeat (3) tick();

      // Simultaneous requests after reset: M0, M1, M0.
      do_reset();
      push_beat(2'b01, 1'b0, 1'b1, 30'h200, 4'hF, wd_of(0, 30'h200, 0), 8'd1);
      push_beat(2'b10, 1'b1, 1'b0, 30'h300, 4'h3, 32'h0, 8'd1);
      push_beat(2'b01, 1'b0, 1'b1, 30'h200, 4'hF, wd_of(0, 30'h200, 1), 8'd1);
      push_run(2'b01, 1);
      push_run(2'b10, 1);
      push_run(2'b01, 1);
      tick();
      fork
         drive_m(0, 1'b0, 1'b1, 30'h200, 8'd1, 2, 0);
         drive_m(1, 1'b1, 1'b0, 30'h300, 8'd1, 1, 0);
      join
      repeat (3) tick();

      // M1 3-beat read, slave stalls two cycles per beat.
      for (int i = 0; i < 3; i++)
         push_beat(2'b10, 1'b1, 1'b0, 30'h340, 4'h3, 32'h0, 8'd3);
      push_run(2'b10, 9);
      tick();
      mode = 1;
      drive_m(1, 1'b1, 1'b0, 30'h340, 8'd3, 3, 0);
      mode = 0;
      repeat (3) tick();

      // BurstCount 0 is a single beat.
      push_beat(2'b01, 1'b0, 1'b1, 30'h400, 4'hF, wd_of(0, 30'h400, 0), 8'd0);
      push_run(2'b01, 1);
      drive_m(0, 1'b0, 1'b1, 30'h400, 8'd0, 1, 0);
      repeat (3) tick();

      // Read and write together is forwarded as a write only.
      push_beat(2'b10, 1'b0, 1'b1, 30'h600, 4'h3, wd_of(1, 30'h600, 0), 8'd1);
      push_run(2'b10, 1);
      drive_m(1, 1'b1, 1'b1, 30'h600, 8'd1, 1, 0);
      repeat (3) tick();

      // Request dropped mid-burst keeps the grant and the beat count.
      push_beat(2'b01, 1'b0, 1'b1, 30'h700, 4'hF, wd_of(0, 30'h700, 0), 8'd2);
      push_beat(2'b01, 1'b0, 1'b1, 30'h700, 4'hF, wd_of(0, 30'h700, 1), 8'd2);
      push_run(2'b01, 4);
      drive_m(0, 1'b0, 1'b1, 30'h700, 8'd2, 2, 2);
      repeat (3) tick();

      // Stuck slave: forced release after 8 stalls, then M1 served.
      to_cnt = 0;
      push_run(2'b01, 8);
      push_run(2'b10, 1);
      push_beat(2'b10, 1'b0, 1'b1, 30'h800, 4'h3, wd_of(1, 30'h800, 0), 8'd1);
      mode = 2;
      set_m(0, 1'b1, 1'b0, 30'h780, 8'd2, '0);
      tick();
      set_m(1, 1'b0, 1'b1, 30'h800, 8'd1, wd_of(1, 30'h800, 0));
      repeat (8) tick();
      mode = 0;
      @(negedge clk);
      chk("to_pulse", tmo, 1'b1);
      chk("to_idle", grant, 2'b00);
      tick();
      set_m(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk("to_next", grant, 2'b10);
      chk("to_once", tmo, 1'b0);
      tick();
      set_m(1, 1'b0, 1'b0, '0, '0, '0);
      repeat (3) tick();
      chk("to_count", to_cnt, 1);

      // Reset during beat 2 of a 4-beat burst.
      push_beat(2'b01, 1'b0, 1'b1, 30'h500, 4'hF, wd_of(0, 30'h500, 0), 8'd4);
      push_run(2'b01, 1);
      set_m(0, 1'b0, 1'b1, 30'h500, 8'd4, wd_of(0, 30'h500, 0));
      tick();
      tick();
      set_m(0, 1'b0, 1'b1, 30'h500, 8'd4, wd_of(0, 30'h500, 1));
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstb_grant", grant, 2'b00);
      chk("rstb_swr", s_wr, 1'b0);
      chk("rstb_saddr", s_addr, 30'h0);
      tick();
      rst_n = 1'b1;
      set_m(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk("rsta_grant", grant, 2'b00);
      chk("rsta_tmo", tmo, 1'b0);
      repeat (4) tick();

      chk("beats_left", exp_beats.size(), 0);
      chk("runs_left", exp_runs.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avalon_burst_arbiter.md
AVALON_BURST_ARBITER -- requirements
Module: avalon_burst_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: stall cycles allowed inside a granted burst before forced release; 0 disables the timeout.
REQ-002 SHALL have port i_Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports i_Mx_AV_Addr  input  30, x in {0,1}: master x word address.
REQ-005 SHALL have ports i_Mx_AV_ByteEn  input  4: master x byte enables.
REQ-006 SHALL have ports i_Mx_AV_Read and i_Mx_AV_Write  input  1 each: master x read and write requests.
REQ-007 SHALL have ports i_Mx_AV_WriteData  input  32: master x write data.
REQ-008 SHALL have ports i_Mx_AV_BurstCount  input  8: master x burst length in beats.
REQ-009 SHALL have ports o_Mx_AV_ReadData  output  32: read data returned to master x.
REQ-010 SHALL have ports o_Mx_AV_WaitRequest  output  1: stall to master x.
REQ-011 SHALL have ports o_S_AV_Addr (30), o_S_AV_ByteEn (4), o_S_AV_Read (1), o_S_AV_Write (1), o_S_AV_WriteData (32), o_S_AV_BurstCount (8)  output: shared slave request.
REQ-012 SHALL have ports i_S_AV_ReadData  input  32 and i_S_AV_WaitRequest  input  1: shared slave response.
REQ-013 SHALL have port o_Grant  output  2: one-hot current owner (bit x = master x); 00 when idle.
REQ-014 SHALL have port o_Timeout  output  1: one-cycle pulse on forced release.

Function
REQ-015 SHALL implement states IDLE, GRANT0, GRANT1 with a registered state.
REQ-016 Master x SHALL be requesting when i_Mx_AV_Read | i_Mx_AV_Write.
REQ-017 In IDLE with exactly one master requesting, next state SHALL be that master's GRANT state.
REQ-018 In IDLE with both masters requesting, grant SHALL go to the master not in r_LastGrant (round-robin); r_LastGrant SHALL update on every grant.
REQ-019 On entering GRANTx, the beat counter SHALL load i_Mx_AV_BurstCount, with 0 loaded as 1.
REQ-020 In GRANTx, all o_S_AV_* request signals SHALL be combinational copies of master x inputs; o_Mx_AV_WaitRequest = i_S_AV_WaitRequest; o_Mx_AV_ReadData = i_S_AV_ReadData.
REQ-021 A master not granted, and both masters in IDLE, SHALL see WaitRequest=1 and ReadData=0; in IDLE, o_S_AV_Read/Write SHALL be 0 and other o_S_* SHALL be 0.
REQ-022 If a granted master asserts Read and Write together, o_S_AV_Read SHALL be 0 and the beat SHALL be treated as a write.
REQ-023 A beat SHALL be accepted when (o_S_AV_Read | o_S_AV_Write) & !i_S_AV_WaitRequest; each accepted beat SHALL decrement the counter by 1.
REQ-024 When the beat accepted has counter==1, next state SHALL be IDLE; IDLE SHALL last at least one cycle between grants (one dead cycle).
REQ-025 A granted master deasserting its request mid-burst SHALL keep the grant; the counter SHALL hold.
REQ-026 The stall counter SHALL reset to 0 on each accepted beat and on each grant, and otherwise SHALL increment while granted.
REQ-027 If TIMEOUT_CYCLES != 0 and the stall counter reaches TIMEOUT_CYCLES, next state SHALL be IDLE and o_Timeout SHALL pulse for exactly one cycle.
REQ-028 Request-to-slave latency SHALL be 1 cycle from IDLE; the first beat can be accepted in the first GRANT cycle.

Reset
REQ-029 On i_Rst_n=0 at a clock edge: state=IDLE, counters=0, r_LastGrant=1 (M0 wins first tie), o_Grant=00, o_Timeout=0, both WaitRequest=1, all o_S_* = 0.
REQ-030 Reset mid-burst SHALL abort the burst immediately with no further slave beats; requests held through reset are arbitrated from IDLE afterwards.

Verification
REQ-031 Single M0 write, BurstCount=4, slave never stalls -> o_Grant=01 for 4 cycles; 4 writes seen at slave; IDLE on 5th cycle; M1 WaitRequest=1 throughout.
REQ-032 Both masters request at the same time after reset, BurstCount=1 -> M0 granted first; M1 granted after one IDLE cycle; with repeated requests grants alternate 01,10,01.
REQ-033 M1 read, BurstCount=3, slave WaitRequest high 2 cycles per beat -> 3 beats accepted; ReadData forwarded only to M1; grant held 9 cycles.
REQ-034 BurstCount=0 -> treated as 1 beat; grant released after the single accepted beat.
REQ-035 TIMEOUT_CYCLES=8, slave WaitRequest stuck high -> o_Timeout pulses once; state IDLE after 8 stall cycles; other master granted next.
REQ-036 i_Rst_n low for 1 cycle during beat 2 of a 4-beat burst -> o_Grant=00 next cycle; no slave strobes during reset.
